dag_circ_addr_gen: RTL and testbench

- Parametrised next-generation data address generator. Holds NUM_REGS banks of index (I), modify (M), length (L) and base (B) registers.
- Per request, produces one data-memory address with pre- or post-modify, circular-buffer wrap and optional bit-reversed output.
- Sits between the program sequencer and data memory, in the same position as the current DAG.
- Register file is written and read over the bus-connect data bus.

---
 rtl/dag_pkg.sv | 29 ++
 rtl/dag_circ_update.sv | 34 +++
 rtl/dag_circ_addr_gen.sv | 113 +++++++++++
 tb/tb_dag_circ_addr_gen.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/dag_pkg.sv
// Shared definitions for the data address generator: register bank codes
// and a width-parameterised bit-reverse helper.
package dag_pkg;

  typedef enum logic [1:0] {
    BANK_I = 2'b00,
    BANK_M = 2'b01,
    BANK_L = 2'b10,
    BANK_B = 2'b11
  } bank_e;

  localparam int MAX_W = 64;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_W-1:0] bit_rev(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] src;
    logic [MAX_W-1:0] r;
    src = v;
    r   = '0;
    for (int k = 0; k < MAX_W; k++) begin
      if (k < w) begin
        r   = {r[MAX_W-2:0], src[0]};
        src = src >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/dag_circ_update.sv
// Combinational modify step: I + M with a single circular wrap inside
// the buffer [B, B+L) whenever L is non-zero.
module dag_circ_update #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0] i_val,
  input  logic [ADDR_WIDTH-1:0] m_val,
  input  logic [ADDR_WIDTH-1:0] l_val,
  input  logic [ADDR_WIDTH-1:0] b_val,
  output logic [ADDR_WIDTH-1:0] next_val
);

  logic [ADDR_WIDTH-1:0] sum;
  logic [ADDR_WIDTH:0]   buf_end;
  logic                  m_neg;

  assign sum     = i_val + m_val;
  // One extra bit so a buffer ending at the top of the address space compares correctly.
  assign buf_end = {1'b0, b_val} + {1'b0, l_val};
  assign m_neg   = m_val[ADDR_WIDTH-1];

  // NOTE: every output of a combinational block gets a default first so no latch is inferred.
  always_comb begin
    next_val = sum;
    if (l_val != '0) begin
      if (!m_neg && ({1'b0, sum} >= buf_end)) begin
        next_val = sum - l_val;
      end else if (m_neg && (sum < b_val)) begin
        next_val = sum + l_val;
      end
    end
  end

endmodule

// File: rtl/dag_circ_addr_gen.sv
// Data address generator: I/M/L/B register banks, one-cycle registered
// address output with pre/post-modify, circular wrap and bit reversal.
module dag_circ_addr_gen
  import dag_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  parameter int SEL_WIDTH  = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ps_dg_en,
  input  logic                  ps_dg_mdfy,
  input  logic                  ps_dg_brev,
  input  logic [SEL_WIDTH-1:0]  ps_dg_iadd,
  input  logic [SEL_WIDTH-1:0]  ps_dg_madd,
  input  logic                  ps_dg_wrt_en,
  input  logic [SEL_WIDTH+1:0]  ps_dg_wrt_add,
  input  logic [SEL_WIDTH+1:0]  ps_dg_rd_add,
  input  logic [DATA_WIDTH-1:0] bc_dt,
  output logic [ADDR_WIDTH-1:0] dg_dm_add,
  output logic                  dg_add_vld,
  output logic [DATA_WIDTH-1:0] dg_bc_dt
);

  logic [ADDR_WIDTH-1:0] i_reg [NUM_REGS];
  logic [ADDR_WIDTH-1:0] m_reg [NUM_REGS];
  logic [ADDR_WIDTH-1:0] l_reg [NUM_REGS];
  logic [ADDR_WIDTH-1:0] b_reg [NUM_REGS];

  logic [ADDR_WIDTH-1:0] cur_i;
  logic [ADDR_WIDTH-1:0] next_i;
  logic [ADDR_WIDTH-1:0] raw_add;
  logic [MAX_W-1:0]      rev_full;
  logic [ADDR_WIDTH-1:0] out_add;
  logic [ADDR_WIDTH-1:0] rd_val;
  logic [ADDR_WIDTH-1:0] wr_val;
  bank_e                 wr_bank;
  bank_e                 rd_bank;
  logic [SEL_WIDTH-1:0]  wr_idx;
  logic [SEL_WIDTH-1:0]  rd_idx;

  assign cur_i   = i_reg[ps_dg_iadd];
  assign wr_bank = bank_e'(ps_dg_wrt_add[SEL_WIDTH+1:SEL_WIDTH]);
  assign wr_idx  = ps_dg_wrt_add[SEL_WIDTH-1:0];
  assign rd_bank = bank_e'(ps_dg_rd_add[SEL_WIDTH+1:SEL_WIDTH]);
  assign rd_idx  = ps_dg_rd_add[SEL_WIDTH-1:0];
  assign wr_val  = bc_dt[ADDR_WIDTH-1:0];

  dag_circ_update #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_update (
    .i_val   (cur_i),
    .m_val   (m_reg[ps_dg_madd]),
    .l_val   (l_reg[ps_dg_iadd]),
    .b_val   (b_reg[ps_dg_iadd]),
    .next_val(next_i)
  );

  assign raw_add  = ps_dg_mdfy ? next_i : cur_i;
  assign rev_full = bit_rev(MAX_W'(raw_add), ADDR_WIDTH);
  assign out_add  = ps_dg_brev ? rev_full[ADDR_WIDTH-1:0] : raw_add;

  always_comb begin
    rd_val = '0;
    case (rd_bank)
      BANK_I:  rd_val = i_reg[rd_idx];
      BANK_M:  rd_val = m_reg[rd_idx];
      BANK_L:  rd_val = l_reg[rd_idx];
      BANK_B:  rd_val = b_reg[rd_idx];
      default: rd_val = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every read in this
  // block sees the pre-edge value and no same-cycle forwarding can occur.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the register banks are architecturally visible and must read 0
      // after reset, so they are cleared here rather than left uninitialised.
      for (int k = 0; k < NUM_REGS; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      dg_dm_add  <= '0;
      dg_add_vld <= 1'b0;
      dg_bc_dt   <= '0;
    end else begin
      dg_add_vld <= ps_dg_en;
      if (ps_dg_en) begin
        dg_dm_add <= out_add;
        if (!ps_dg_mdfy) begin
          i_reg[ps_dg_iadd] <= next_i;
        end
      end
      // Placed after the post-modify update so an explicit I write to the same index wins.
      if (ps_dg_wrt_en) begin
        case (wr_bank)
          BANK_I:  i_reg[wr_idx] <= wr_val;
          BANK_M:  m_reg[wr_idx] <= wr_val;
          BANK_L:  l_reg[wr_idx] <= wr_val;
          BANK_B:  b_reg[wr_idx] <= wr_val;
          default: ;
        endcase
      end
      dg_bc_dt <= DATA_WIDTH'(rd_val);
    end
  end

endmodule

// File: tb/tb_dag_circ_addr_gen.sv
// Directed plus randomized bench for dag_circ_addr_gen against an arithmetic
// reference model of the register banks.
module tb_dag_circ_addr_gen;

  localparam int AW = 16;
  localparam int NR = 8;
  localparam int SW = 3;
  localparam int DW = 16;

  localparam int BI = 0;
  localparam int BM = 8;
  localparam int BL = 16;
  localparam int BB = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          ps_dg_en = 1'b0;
  logic          ps_dg_mdfy = 1'b0;
  logic          ps_dg_brev = 1'b0;
  logic [SW-1:0] ps_dg_iadd = '0;
  logic [SW-1:0] ps_dg_madd = '0;
  logic          ps_dg_wrt_en = 1'b0;
  logic [SW+1:0] ps_dg_wrt_add = '0;
  logic [SW+1:0] ps_dg_rd_add = '0;
  logic [DW-1:0] bc_dt = '0;
  logic [AW-1:0] dg_dm_add;
  logic          dg_add_vld;
  logic [DW-1:0] dg_bc_dt;

  dag_circ_addr_gen #(
    .ADDR_WIDTH(AW), .NUM_REGS(NR), .SEL_WIDTH(SW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .ps_dg_en(ps_dg_en), .ps_dg_mdfy(ps_dg_mdfy),
    .ps_dg_brev(ps_dg_brev), .ps_dg_iadd(ps_dg_iadd), .ps_dg_madd(ps_dg_madd),
    .ps_dg_wrt_en(ps_dg_wrt_en), .ps_dg_wrt_add(ps_dg_wrt_add),
    .ps_dg_rd_add(ps_dg_rd_add), .bc_dt(bc_dt), .dg_dm_add(dg_dm_add),
    .dg_add_vld(dg_add_vld), .dg_bc_dt(dg_bc_dt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: banks[bank*8+idx]; address held across idle cycles.
  int model_reg [32];
  int held_add = 0;

  function automatic int model_next(input int i, input int m, input int l, input int b);
    int sum;
    sum = (i + m) % 65536;
    if (l == 0) return sum;
    if (m < 32768) begin
      if (sum >= b + l) return (sum - l + 65536) % 65536;
      return sum;
    end
    if (sum < b) return (sum + l) % 65536;
    return sum;
  endfunction

  function automatic int reverse16(input int v);
    int r = 0;
    for (int k = 0; k < AW; k++)
      if (((v >> k) & 1) == 1) r = r + (1 << (AW - 1 - k));
    return r;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic cyc(input string tag, input bit rst_n, input bit en, input bit mdfy,
                     input bit brev, input int iadd, input int madd, input bit we,
                     input int wa, input int ra, input int dt);
    int nx, raw, e_add, e_vld, e_rd;
    reset = rst_n; ps_dg_en = en; ps_dg_mdfy = mdfy; ps_dg_brev = brev;
    ps_dg_iadd = SW'(iadd); ps_dg_madd = SW'(madd); ps_dg_wrt_en = we;
    ps_dg_wrt_add = (SW+2)'(wa); ps_dg_rd_add = (SW+2)'(ra); bc_dt = DW'(dt);
    if (!rst_n) begin
      foreach (model_reg[k]) model_reg[k] = 0;
      held_add = 0; e_vld = 0; e_rd = 0;
    end else begin
      e_rd  = model_reg[ra];
      e_vld = en ? 1 : 0;
      nx = model_next(model_reg[BI+iadd], model_reg[BM+madd],
                      model_reg[BL+iadd], model_reg[BB+iadd]);
      if (en) begin
        raw = mdfy ? nx : model_reg[BI+iadd];
        held_add = brev ? reverse16(raw) : raw;
        if (!mdfy) model_reg[BI+iadd] = nx;
      end
      if (we) model_reg[wa] = dt % 65536;
    end
    e_add = held_add;
    @(posedge clk);
    #1;
    check({tag, ".vld"}, int'(dg_add_vld), e_vld);
    check({tag, ".add"}, int'(dg_dm_add), e_add);
    check({tag, ".rd"},  int'(dg_bc_dt), e_rd);
  endtask

  task automatic wr(input int wa, input int dt);
    cyc("wr", 1, 0, 0, 0, 0, 0, 1, wa, 0, dt);
  endtask

  initial begin
    int wa, dt, l;
    cyc("rst0", 0, 1, 0, 0, 0, 0, 1, BI, 0, 16'h1234);
    cyc("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset clears a loaded register and the outputs.
    wr(BI + 0, 5);
    cyc("rd_i0", 1, 1, 0, 0, 0, 0, 0, 0, BI + 0, 0);
    check("pre_rst_i0", int'(dg_bc_dt), 5);
    cyc("rstp", 0, 1, 0, 0, 0, 0, 0, 0, BI + 0, 0);
    cyc("post_rst", 1, 0, 0, 0, 0, 0, 0, 0, BI + 0, 0);
    check("rst_i0", int'(dg_bc_dt), 0);
    check("rst_vld", int'(dg_add_vld), 0);

    // Linear post-modify.
    wr(BI + 0, 16'h0100); wr(BM + 0, 4);
    cyc("lin0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("lin0_d", int'(dg_dm_add), 16'h0100);
    cyc("lin1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("lin1_d", int'(dg_dm_add), 16'h0104);
    cyc("lin2", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("lin2_d", int'(dg_dm_add), 16'h0108);
    cyc("linh", 1, 0, 0, 0, 0, 0, 0, 0, BI + 0, 0);
    check("lin_hold", int'(dg_dm_add), 16'h0108);
    check("lin_i0", int'(dg_bc_dt), 16'h010C);

    // Circular wrap, positive modify.
    wr(BB + 1, 16'h0200); wr(BL + 1, 8); wr(BI + 1, 16'h0206); wr(BM + 1, 3);
    cyc("cp0", 1, 1, 0, 0, 1, 1, 0, 0, 0, 0); check("cp0_d", int'(dg_dm_add), 16'h0206);
    cyc("cp1", 1, 1, 0, 0, 1, 1, 0, 0, 0, 0); check("cp1_d", int'(dg_dm_add), 16'h0201);
    cyc("cpr", 1, 0, 0, 0, 0, 0, 0, 0, BI + 1, 0); check("cp_i1", int'(dg_bc_dt), 16'h0204);

    // Circular wrap, negative modify, pre-modify leaves I alone.
    wr(BI + 1, 16'h0201); wr(BM + 1, 16'hFFFD);
    cyc("cn0", 1, 1, 1, 0, 1, 1, 0, 0, 0, 0); check("cn0_d", int'(dg_dm_add), 16'h0206);
    cyc("cnr", 1, 0, 0, 0, 0, 0, 0, 0, BI + 1, 0); check("cn_i1", int'(dg_bc_dt), 16'h0201);

    // Bit reverse.
    wr(BI + 2, 1); wr(BM + 2, 0);
    cyc("br0", 1, 1, 0, 1, 2, 2, 0, 0, 0, 0); check("br0_d", int'(dg_dm_add), 16'h8000);

    // Collision: explicit write beats post-modify; same-cycle read sees old value.
    wr(BI + 3, 16'h10); wr(BM + 3, 1);
    cyc("col0", 1, 1, 0, 0, 3, 3, 1, BI + 3, BI + 3, 16'h55);
    check("col_add", int'(dg_dm_add), 16'h10);
    check("col_old", int'(dg_bc_dt), 16'h10);
    cyc("col1", 1, 0, 0, 0, 0, 0, 0, 0, BI + 3, 0);
    check("col_new", int'(dg_bc_dt), 16'h55);

    // Randomized traffic with small modifies and modest buffer lengths.
    for (int n = 0; n < 400; n++) begin
      wa = int'($urandom_range(0, 31));
      case (wa / 8)
        1:       dt = (int'($urandom_range(0, 8)) - 4 + 65536) % 65536;
        2:       dt = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(8, 40));
        default: dt = int'($urandom_range(0, 65535));
      endcase
      l = int'($urandom_range(0, 99));
      cyc("rnd", l != 0, 1'($urandom), 1'($urandom), 1'($urandom),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          ($urandom_range(0, 9) < 3), wa, int'($urandom_range(0, 31)), dt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
